// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register word indices, CTRL bits
// and the byte-lane merge used by every writable register.
package mtimer_pkg;
  localparam logic [3:0] MTIME_LO    = 4'd0;
  localparam logic [3:0] MTIME_HI    = 4'd1;
  localparam logic [3:0] MTIMECMP_LO = 4'd2;
  localparam logic [3:0] MTIMECMP_HI = 4'd3;
  localparam logic [3:0] CTRL        = 4'd4;
  localparam logic [3:0] STATUS      = 4'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction
endpackage

// File: rtl/mtimer_tick_gen.sv
// Prescaler: one-cycle tick every Div enabled cycles; held at 0 while disabled.
module tick_gen #(
  parameter int Div = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CW-1:0] LAST = CW'(Div - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign tick = en && (cnt_q == LAST);
endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp, CTRL/STATUS, shadowed HI read
// for atomic LO-then-HI pairs, registered read data and level interrupt.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int ClockFreqHz = 50_000_000,
  parameter int TickHz      = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byte_en_i,
  input  logic        wr_i,
  input  logic        addr_strobe_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  localparam int Div = ClockFreqHz / TickHz;

  if (Div < 1) begin : g_bad_div
    $error("mtimer: ClockFreqHz/TickHz must be >= 1");
  end

  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] hi_shadow_q, hi_shadow_d, rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        tick, wr_en, rd_en, cmp_ge;

  tick_gen #(.Div(Div)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ctrl_q[CTRL_EN]),
    .tick (tick)
  );

  assign wr_en  = addr_strobe_i &  wr_i;
  assign rd_en  = addr_strobe_i & ~wr_i;
  assign cmp_ge = mtime_q >= mtimecmp_q;
  assign irq_d  = ctrl_q[CTRL_IRQ_EN] & cmp_ge;

  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    ctrl_d      = ctrl_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = rdata_q;
    // A write to either mtime half overrides the tick increment for that cycle.
    if (wr_en) begin
      case (addr_i)
        MTIME_LO:    mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], wdata_i, byte_en_i)};
        MTIME_HI:    mtime_d = {be_merge(mtime_q[63:32], wdata_i, byte_en_i), mtime_q[31:0]};
        MTIMECMP_LO: mtimecmp_d[31:0]  = be_merge(mtimecmp_q[31:0], wdata_i, byte_en_i);
        MTIMECMP_HI: mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], wdata_i, byte_en_i);
        CTRL:        if (byte_en_i[0]) ctrl_d = wdata_i[1:0];
        default: ;
      endcase
    end
    if (rd_en) begin
      case (addr_i)
        MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        MTIME_HI:    rdata_d = hi_shadow_q;
        MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        CTRL:        rdata_d = {30'd0, ctrl_q};
        STATUS:      rdata_d = {31'd0, cmp_ge};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      ctrl_q      <= '0;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ctrl_q      <= ctrl_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;
endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: directed scenarios plus random bus traffic, with every
// cycle's rdata_o/irq_o compared against a behavioural timer model.
module tb_mtimer;
  localparam int CLK_HZ  = 50_000_000;
  localparam int TICK_HZ = 1_000_000;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [3:0]  addr = '0, be = '0;
  logic [31:0] wdata = '0, rdata;
  logic        wr = 1'b0, stb = 1'b0, irq;

  int n_cmp = 0, n_err = 0;

  mtimer #(.ClockFreqHz(CLK_HZ), .TickHz(TICK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr), .wdata_i(wdata), .byte_en_i(be),
    .wr_i(wr), .addr_strobe_i(stb), .rdata_o(rdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a 64-bit counter advanced every DIV enabled cycles.
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_shadow, m_rdata;
  logic        m_en, m_ien, m_irq;
  int          m_pre;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_time <= '0; m_cmp <= '1; m_shadow <= '0; m_rdata <= '0;
      m_en <= 1'b0; m_ien <= 1'b0; m_irq <= 1'b0; m_pre <= 0;
    end else begin
      m_irq <= m_ien && (m_time >= m_cmp);
      m_pre <= (!m_en || m_pre == DIV - 1) ? 0 : m_pre + 1;
      if (stb && wr && addr == 4'd0)
        m_time <= {m_time[63:32], lanes(m_time[31:0], wdata, be)};
      else if (stb && wr && addr == 4'd1)
        m_time <= {lanes(m_time[63:32], wdata, be), m_time[31:0]};
      else if (m_en && m_pre == DIV - 1)
        m_time <= m_time + 64'd1;
      if (stb && wr) begin
        if (addr == 4'd2) m_cmp[31:0]  <= lanes(m_cmp[31:0], wdata, be);
        if (addr == 4'd3) m_cmp[63:32] <= lanes(m_cmp[63:32], wdata, be);
        if (addr == 4'd4 && be[0]) begin m_en <= wdata[0]; m_ien <= wdata[1]; end
      end
      if (stb && !wr) begin
        case (addr)
          4'd0: begin m_rdata <= m_time[31:0]; m_shadow <= m_time[63:32]; end
          4'd1: m_rdata <= m_shadow;
          4'd2: m_rdata <= m_cmp[31:0];
          4'd3: m_rdata <= m_cmp[63:32];
          4'd4: m_rdata <= {30'd0, m_ien, m_en};
          4'd5: m_rdata <= {31'd0, m_time >= m_cmp};
          default: m_rdata <= '0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("rdata", rdata, m_rdata);
    chk("irq", irq, m_irq);
  end

  task automatic do_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
    stb = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    stb = 1'b0; wr = 1'b0; addr = '0;
  endtask

  task automatic do_rd(input logic [3:0] a, output logic [31:0] d);
    stb = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    stb = 1'b0; addr = '0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] v;

  initial begin
    #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", irq, 1'b0);
    do_rd(4'd2, v); chk("cmp_lo_rst", v, 32'hFFFF_FFFF);
    do_rd(4'd3, v); chk("cmp_hi_rst", v, 32'hFFFF_FFFF);

    // 500 enabled cycles at 1 MHz ticks from 50 MHz -> 10 ticks.
    do_wr(4'd4, 32'h1);
    idle(500);
    do_rd(4'd0, v); chk("tick500", v, 32'd10);
    do_wr(4'd4, 32'h0);
    idle(200);
    do_rd(4'd0, v); chk("frozen", v, 32'd10);

    // Carry from LO into HI.
    do_wr(4'd1, 32'h0);
    do_wr(4'd0, 32'hFFFF_FFFF);
    do_wr(4'd4, 32'h1);
    idle(55);
    do_rd(4'd0, v); chk("carry_lo", v, 32'h0);
    do_rd(4'd1, v); chk("carry_hi", v, 32'h1);

    // HI returns the value shadowed by the preceding LO read.
    do_wr(4'd4, 32'h0);
    do_wr(4'd1, 32'h0);
    do_wr(4'd0, 32'hFFFF_FFFF);
    do_wr(4'd4, 32'h1);
    do_rd(4'd0, v); chk("shadow_lo", v, 32'hFFFF_FFFF);
    idle(160);
    do_rd(4'd1, v); chk("shadow_hi", v, 32'h0);
    do_rd(4'd0, v); chk("after_lo", v, 32'h2);
    do_rd(4'd1, v); chk("after_hi", v, 32'h1);

    // Compare and interrupt.
    do_wr(4'd4, 32'h0);
    do_wr(4'd0, 32'h0);
    do_wr(4'd1, 32'h0);
    do_wr(4'd2, 32'd20);
    do_wr(4'd3, 32'h0);
    do_wr(4'd4, 32'h3);
    for (int i = 0; i < 1200 && !irq; i++) idle(1);
    chk("irq_rise", irq, 1'b1);
    do_rd(4'd0, v); chk("irq_time", v, 32'd20);
    do_rd(4'd5, v); chk("status_ge", v, 32'h1);
    do_wr(4'd2, 32'd100);
    chk("irq_hold", irq, 1'b1);
    idle(1);
    chk("irq_fall", irq, 1'b0);

    // Mid-operation reset, then a single-lane write.
    rst_pulse();
    chk("rst2_rdata", rdata, 32'h0);
    chk("rst2_irq", irq, 1'b0);
    do_wr(4'd2, 32'h0000_AB00, 4'b0010);
    do_rd(4'd2, v); chk("byte_en", v, 32'hFFFF_ABFF);

    // MTIME_LO write in a tick cycle wins over the increment.
    do_wr(4'd4, 32'h1);
    for (int i = 0; i < 2 * DIV && m_pre != DIV - 1; i++) idle(1);
    chk("tick_align", m_pre, DIV - 1);
    do_wr(4'd0, 32'd5);
    do_rd(4'd0, v); chk("wr_tick_lo", v, 32'd5);
    do_rd(4'd1, v); chk("wr_tick_hi", v, 32'd0);

    // Random traffic; the per-cycle monitor checks every response.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst_pulse();
      stb   = ($urandom_range(0, 3) != 0);
      wr    = $urandom_range(0, 1);
      addr  = 4'($urandom_range(0, 7));
      be    = 4'($urandom);
      wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (addr == 4'd4 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
      @(negedge clk);
    end
    stb = 1'b0; wr = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
